result_drain: RTL and testbench
===============================

# result_drain

Downstream stage of the calculator datapath. Once the controller has finished, this block reads the result region of operand/result memory, from `write_start_addr` to `write_end_addr`. It streams each 64-bit result word out as two 32-bit beats on a valid/ready interface, lower half first. A 2-entry word prefetch buffer hides the 1-cycle memory read latency, so the stream sustains one beat per cycle.

## Interface
- Parameters: `ADDR_W`, `DATA_W` (32) and `MEM_WORD_SIZE` (64) come from `calculator_pkg`, not module parameters.
- `PREFETCH_DEPTH`, default 2 — word-buffer entries; legal values 2 or 4.
- `clk_i` in 1 — single clock; all logic on the rising edge.
- `rst_ni` in 1 — asynchronous, active-low reset.
- `start_i` in 1 — one-cycle start pulse, driven from controller end-state detect.
- `write_start_addr` in ADDR_W — first result word address; sampled on accepted start.
- `write_end_addr` in ADDR_W — last result word address, inclusive; sampled on accepted start.
- `read_o` in-to-memory out 1 — memory read strobe.
- `r_addr_o` out ADDR_W — memory read address.
- `r_data_i` in MEM_WORD_SIZE — read data, valid the cycle after `read_o`.
- `m_valid_o` out 1 — stream beat valid.
- `m_ready_i` in 1 — stream sink ready.
- `m_data_o` out DATA_W — beat data.
- `m_last_o` out 1 — marks the final beat (upper half of the last word).
- `busy_o` out 1 — high from accepted start until done.
- `done_o` out 1 — one-cycle pulse when the drain completes.

## Operation
- States: S_IDLE, S_RUN, S_DONE.
- S_IDLE:
  - `start_i` is accepted; both addresses are latched.
  - `words_left` = end − start + 1 (ADDR_W+1 bits).
  - If start > end, go to S_DONE with no reads; otherwise go to S_RUN.
- S_RUN, fetch:
  - Issue `read_o` at `rd_ptr` whenever `words_left` ≠ 0 and (buffer occupancy + in-flight read) < PREFETCH_DEPTH.
  - On each issue, `rd_ptr`++ and `words_left`--.
  - The pointer never wraps. `words_left` uses the extra bit, so end = 2^ADDR_W−1 is legal.
- S_RUN, capture:
  - `r_data_i` is pushed into the buffer in the cycle after `read_o`.
  - The fetch rule guarantees the buffer is never full on a push.
- S_RUN, emit:
  - The head word is emitted as `[DATA_W-1:0]`, then `[MEM_WORD_SIZE-1:DATA_W]`.
  - A `half` flag selects the half; the word pops on handshake of the upper half.
- S_RUN to S_DONE: after the handshake of the beat with `m_last_o` set.
- S_DONE: `done_o`=1 for one cycle, then return to S_IDLE.
- `start_i` while `busy_o`=1 is ignored.
- Handshake rules:
  - Transfer happens when `m_valid_o` && `m_ready_i`.
  - Once `m_valid_o` is high, it stays high, and `m_data_o`/`m_last_o` stay stable, until the transfer.
  - `m_valid_o` never depends combinationally on `m_ready_i`.
- Reset: asynchronous assertion at any time, including mid-drain or with a read in flight.
  - Everything returns to S_IDLE and the buffer empties.
  - Any read data returning after reset is discarded.

## Timing
- Reset values: `read_o`=0, `r_addr_o`=0, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `busy_o`=0, `done_o`=0.
- Start pulse in cycle 0 leads to:
  - cycle 1: `read_o`=1, `r_addr_o`=start;
  - cycle 2: data captured;
  - cycle 3: first `m_valid_o`.
- With `m_ready_i` held at 1, beats are back-to-back: 2N beats over cycles 3 … 2N+2.
- After the last handshake in cycle T, `done_o`=1 in cycle T+1.
- When start > end, `done_o`=1 in cycle 1.
- `busy_o` is high from cycle 1 through the `done_o` cycle.

## Structure
- `calculator_pkg` holds `ADDR_W`, `DATA_W`, `MEM_WORD_SIZE` and the `drain_state_t` enum.
- One sub-module, `word_fifo`: a synchronous FIFO, MEM_WORD_SIZE wide, PREFETCH_DEPTH deep.
  - Ports: push, pop, full, empty, count.
  - Asynchronous active-low reset.

## Test plan
- Memory words 0x2_0000_0001 at addr 4 and 0x4_0000_0003 at addr 5; start=4, end=5; `m_ready_i`=1 → beats 1, 2, 3, 4 in cycles 3–6; `m_last_o` on beat 4; `done_o` in cycle 7.
- Same setup with `m_ready_i` toggling 1,0,1,0 → identical beat order, data stable while stalled, at most 2 reads outstanding.
- start=7, end=3 → no `read_o`, `done_o` in cycle 1, `m_valid_o` never high.
- start=end=2^ADDR_W−1 → exactly one read, 2 beats, no pointer wrap, `done_o` pulses.
- `rst_ni` driven low after the second beat with a read in flight → all outputs 0 immediately; a new start afterwards drains correctly from the beginning.
- `start_i` re-pulsed mid-drain → ignored; beat count unchanged.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared widths and drain FSM state type for the calculator datapath.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package calculator_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } drain_state_t;

endpackage

// File: rtl/result_drain_if.sv
// Memory read port plus 32-bit result stream of the result drain.
// Latency: memory data returns the cycle after read_o.
// Backpressure: stream uses valid/ready; the memory port has none.
interface result_drain_if;
  import calculator_pkg::*;

  logic                     read_o;
  logic [ADDR_W-1:0]        r_addr_o;
  logic [MEM_WORD_SIZE-1:0] r_data_i;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic [DATA_W-1:0]        m_data_o;
  logic                     m_last_o;

  modport master (
    output read_o, r_addr_o,
    input  r_data_i,
    output m_valid_o, m_data_o, m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  read_o, r_addr_o,
    output r_data_i,
    input  m_valid_o, m_data_o, m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/result_drain_word_fifo.sv
// Small synchronous FIFO holding prefetched result words.
// Latency: a pushed word is visible at data_o the cycle after the push.
// Backpressure: push is dropped when full, pop ignored when empty; the caller prevents both.
module word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  // DEPTH is a power of two, so the pointers wrap naturally.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array: written on push, contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// Reads result words from memory and streams each as two 32-bit beats, low half first.
// Latency: start in cycle 0 -> read in cycle 1 -> first beat valid in cycle 3.
// Backpressure: m_ready_i low holds the beat; prefetch stops once buffer plus in-flight read fill it.
module result_drain
  import calculator_pkg::*;
#(
  parameter int PREFETCH_DEPTH = 2  // 2 or 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr,
  result_drain_if.master    bus,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(PREFETCH_DEPTH + 1);

  drain_state_t             state_q, state_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          words_left_q, words_left_d;
  logic                     half_q, half_d;
  logic                     inflight_q;

  logic                     issue;
  logic                     pop;
  logic                     beat_xfer;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [MEM_WORD_SIZE-1:0] head;
  logic [CNT_W:0]           occupancy;
  logic [ADDR_W:0]          span;

  // Extra bit lets a region ending at the top address count correctly.
  assign span      = ({1'b0, write_end_addr} - {1'b0, write_start_addr}) + (ADDR_W+1)'(1);
  // Words buffered plus a read whose data has not landed yet.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);

  assign issue = (state_q == S_RUN) && (words_left_q != '0) && !fifo_full
              && (occupancy < (CNT_W+1)'(PREFETCH_DEPTH));

  assign bus.read_o    = issue;
  assign bus.r_addr_o  = rd_ptr_q;
  // Valid depends only on registered state, never on m_ready_i.
  assign bus.m_valid_o = (state_q == S_RUN) && !fifo_empty;
  assign bus.m_data_o  = !bus.m_valid_o ? '0
                       : half_q ? head[MEM_WORD_SIZE-1:DATA_W] : head[DATA_W-1:0];
  // Final beat: upper half of the only remaining word with nothing left to fetch.
  // Once true for a held beat it stays true, and vice versa, so it is stable under stall.
  assign bus.m_last_o  = bus.m_valid_o && half_q && (words_left_q == '0) && !inflight_q
                      && (fifo_count == CNT_W'(1));

  assign beat_xfer = bus.m_valid_o && bus.m_ready_i;
  assign pop       = beat_xfer && half_q;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

  word_fifo #(
    .WIDTH (MEM_WORD_SIZE),
    .DEPTH (PREFETCH_DEPTH)
  ) u_word_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (bus.r_data_i),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state: start acceptance, fetch pointer/count, half select, completion.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    words_left_d = words_left_q;
    half_d       = half_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rd_ptr_d     = write_start_addr;
          words_left_d = span;
          half_d       = 1'b0;
          state_d      = (write_start_addr > write_end_addr) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          words_left_d = words_left_q - 1'b1;
          // Hold the pointer after the final read so it never wraps.
          if (words_left_q != (ADDR_W+1)'(1)) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (beat_xfer) begin
          half_d = ~half_q;
          if (bus.m_last_o) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; clearing inflight_q on reset discards any late read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      words_left_q <= '0;
      half_q       <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      words_left_q <= words_left_d;
      half_q       <= half_d;
      inflight_q   <= issue;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain with a memory model and beat scoreboard.
// Latency: checks cycle-exact timing when the sink is always ready.
// Backpressure: exercises always-ready, alternating and random sinks.
module tb_result_drain;
  import calculator_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] sa = '0;
  logic [ADDR_W-1:0] ea = '0;
  logic              busy_o;
  logic              done_o;

  result_drain_if bus ();

  result_drain #(.PREFETCH_DEPTH(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .write_start_addr (sa),
    .write_end_addr   (ea),
    .bus              (bus.master),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mem [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Memory: data for a read seen in one cycle appears in the next; junk otherwise.
  initial begin : mem_resp
    logic              rd;
    logic [ADDR_W-1:0] a;
    bus.r_data_i = '0;
    forever begin
      @(negedge clk_i);
      rd = bus.read_o;
      a  = bus.r_addr_o;
      @(posedge clk_i);
      #1;
      bus.r_data_i = rd ? mem[a] : {$urandom, $urandom};
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, ":read"},  bus.read_o,    0);
    chk({nm, ":raddr"}, bus.r_addr_o,  0);
    chk({nm, ":valid"}, bus.m_valid_o, 0);
    chk({nm, ":data"},  bus.m_data_o,  0);
    chk({nm, ":last"},  bus.m_last_o,  0);
    chk({nm, ":busy"},  busy_o,        0);
    chk({nm, ":done"},  done_o,        0);
  endtask

  // One drain: start in cycle 0, observe every cycle, score against the memory image.
  task automatic drain(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                       input int rmode, input int restart_cyc, input int rst_cyc,
                       input string nm);
    logic [31:0] exp_dat[$];
    bit          exp_last[$];
    int          n_words, n_reads, n_pop, max_out, beats, last_hs, done_cyc, first_valid;
    logic        prev_stall, prev_last;
    logic [31:0] prev_dat;

    n_words = (s <= e) ? (int'(e) - int'(s) + 1) : 0;
    for (int a = int'(s); a <= int'(e); a++) begin
      exp_dat.push_back(mem[a][31:0]);
      exp_last.push_back(1'b0);
      exp_dat.push_back(mem[a][63:32]);
      exp_last.push_back(a == int'(e));
    end
    n_reads = 0; n_pop = 0; max_out = 0; beats = 0; last_hs = -1;
    done_cyc = -1; first_valid = -1; prev_stall = 1'b0; prev_last = 1'b0; prev_dat = '0;

    @(posedge clk_i); #1;
    sa = s; ea = e; start_i = 1'b1; bus.m_ready_i = rdy(rmode, 0);

    for (int c = 0; c < 40 * n_words + 20; c++) begin
      @(negedge clk_i);
      chk({nm, ":busy"}, busy_o, c >= 1);
      if (c == 1 && rmode == 0 && n_words > 0) chk({nm, ":read_c1"}, bus.read_o, 1);
      if (bus.read_o) begin
        chk({nm, ":raddr"}, bus.r_addr_o, int'(s) + n_reads);
        n_reads++;
      end
      if (n_reads - n_pop > max_out) max_out = n_reads - n_pop;
      if (bus.m_valid_o) begin
        if (first_valid < 0) first_valid = c;
        if (prev_stall) begin
          chk({nm, ":stable_dat"},  bus.m_data_o, prev_dat);
          chk({nm, ":stable_last"}, bus.m_last_o, prev_last);
        end
        if (bus.m_ready_i) begin
          if (beats < exp_dat.size()) begin
            chk({nm, ":beat_dat"},  bus.m_data_o, exp_dat[beats]);
            chk({nm, ":beat_last"}, bus.m_last_o, exp_last[beats]);
          end else begin
            chk({nm, ":extra_beat"}, beats, exp_dat.size());
          end
          if (beats % 2 == 1) n_pop++;
          beats++;
          last_hs = c;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_dat   = bus.m_data_o;
          prev_last  = bus.m_last_o;
        end
      end else begin
        if (prev_stall) chk({nm, ":valid_held"}, bus.m_valid_o, 1);
        prev_stall = 1'b0;
      end
      if (c == rst_cyc) begin
        chk({nm, ":inflight"}, bus.read_o, 1);
        #1 rst_ni = 1'b0;
        #1 chk_all_zero({nm, ":rst"});
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        start_i = 1'b0;
        return;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      @(posedge clk_i); #1;
      start_i = (c + 1 == restart_cyc);
      if (start_i) begin
        sa = ADDR_W'($urandom_range(0, 255));
        ea = ADDR_W'($urandom_range(0, 255));
      end
      bus.m_ready_i = rdy(rmode, c + 1);
    end

    chk({nm, ":done_seen"}, done_cyc >= 0, 1);
    chk({nm, ":done_cyc"}, done_cyc, (n_words > 0) ? last_hs + 1 : 1);
    chk({nm, ":beats"}, beats, 2 * n_words);
    chk({nm, ":reads"}, n_reads, n_words);
    chk({nm, ":outstanding_le2"}, max_out <= 2, 1);
    if (n_words == 0) chk({nm, ":no_valid"}, first_valid < 0, 1);
    if (rmode == 0 && n_words > 0) begin
      chk({nm, ":first_valid"}, first_valid, 3);
      chk({nm, ":done_at"}, done_cyc, 2 * n_words + 3);
    end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk({nm, ":done_pulse"}, done_o, 0);
    chk({nm, ":idle_busy"}, busy_o, 0);
    chk({nm, ":idle_valid"}, bus.m_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    mem[4] = 64'h0000_0002_0000_0001;
    mem[5] = 64'h0000_0004_0000_0003;
    bus.m_ready_i = 1'b0;
    rst_ni = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    drain(8'd4,   8'd5,   0, -1, -1, "basic");
    drain(8'd4,   8'd5,   1, -1, -1, "toggle");
    drain(8'd7,   8'd3,   0, -1, -1, "reversed");
    drain(8'd255, 8'd255, 0, -1, -1, "top_addr");
    drain(8'd10,  8'd13,  0, -1,  5, "mid_reset");
    drain(8'd10,  8'd13,  0, -1, -1, "post_reset");
    drain(8'd20,  8'd23,  0,  4, -1, "restart");
    for (int t = 0; t < 6; t++) begin
      int s;
      s = $urandom_range(0, 250);
      drain(ADDR_W'(s), ADDR_W'(s + $urandom_range(0, 5)), 2, -1, -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
